// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes, freezes on data-memory wait.
// Latency: control outputs are combinational from the registered state and the current inputs.
// Backpressure: holds the whole pipe while dmem is busy, and goes to ERR after MAX_WAIT wait cycles.
module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic [4:0]       Rd_EX,
    input  logic             MemRead_EX,
    input  logic             Branch_Taken_Mem,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             Pipe_Hold,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

    localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_set;

    logic mem_stall;
    logic load_use;
    logic rd_is_xzr;

    assign mem_stall = dmem_req & ~dmem_ready;
    // XZR as a destination discards the result, so it can never feed a dependent instruction.
    assign rd_is_xzr = (Rd_EX == 5'd31);
    assign load_use  = MemRead_EX & ~rd_is_xzr & ((Rd_EX == Rn_ID) | (Rd_EX == Rm_ID));

    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        Pipe_Hold   = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_set = 1'b0;

        if (!reset) begin
            case (state_q)
                ST_RUN, ST_WAIT: begin
                    if (mem_stall) begin
                        // A frozen EX/MEM keeps any taken branch, which is seen again on release.
                        Pipe_Hold  = 1'b1;
                        PC_Write   = 1'b0;
                        IFID_Write = 1'b0;
                        if (state_q == ST_RUN) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = 8'd1;
                        end else if (wait_cnt_q == MAX_WAIT_C) begin
                            state_d     = ST_ERR;
                            timeout_set = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d    = ST_RUN;
                        wait_cnt_d = 8'd0;
                        if (Branch_Taken_Mem) begin
                            IFID_Flush  = 1'b1;
                            IDEX_Flush  = 1'b1;
                            EXMEM_Flush = 1'b1;
                        end else if (load_use) begin
                            PC_Write    = 1'b0;
                            IFID_Write  = 1'b0;
                            IDEX_Bubble = 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    Pipe_Hold  = 1'b1;
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                end
                default: begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
            if (!PC_Write && stall_count != CNT_MAX) begin
                stall_count <= stall_count + 1'b1;
            end
            if (IFID_Flush && flush_count != CNT_MAX) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a short timeout and 2-bit counters.
module tb_hazard_stall_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       Rn_ID, Rm_ID, Rd_EX;
    logic             MemRead_EX, Branch_Taken_Mem, dmem_req, dmem_ready;
    logic             PC_Write, IFID_Write, IDEX_Bubble;
    logic             IFID_Flush, IDEX_Flush, EXMEM_Flush, Pipe_Hold, mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_checks = 0;
    int n_fails  = 0;

    hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .Rn_ID            (Rn_ID),
        .Rm_ID            (Rm_ID),
        .Rd_EX            (Rd_EX),
        .MemRead_EX       (MemRead_EX),
        .Branch_Taken_Mem (Branch_Taken_Mem),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .PC_Write         (PC_Write),
        .IFID_Write       (IFID_Write),
        .IDEX_Bubble      (IDEX_Bubble),
        .IFID_Flush       (IFID_Flush),
        .IDEX_Flush       (IDEX_Flush),
        .EXMEM_Flush      (EXMEM_Flush),
        .Pipe_Hold        (Pipe_Hold),
        .mem_timeout      (mem_timeout),
        .state            (state),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; combinational checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic idle_inputs();
        Rn_ID = 5'd0; Rm_ID = 5'd0; Rd_EX = 5'd0;
        MemRead_EX = 1'b0; Branch_Taken_Mem = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        chk(tag, {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush, Pipe_Hold}, {25'd0, exp});
    endtask

    // Control vectors: {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush, Pipe_Hold}
    localparam logic [6:0] C_DEF   = 7'b1100000;
    localparam logic [6:0] C_LU    = 7'b0010000;
    localparam logic [6:0] C_FLUSH = 7'b1101110;
    localparam logic [6:0] C_HOLD  = 7'b0000001;

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        // Reset forces default controls even with a load-use hazard present
        MemRead_EX = 1'b1; Rd_EX = 5'd5; Rn_ID = 5'd5;
        mid();
        chk_ctrl("reset_ctrl_default", C_DEF);
        tick();
        idle_inputs();
        reset = 1'b0;
        chk("reset_state", state, 2'b00);
        chk("reset_stall_cnt", stall_count, 0);
        chk("reset_flush_cnt", flush_count, 0);
        chk("reset_timeout", mem_timeout, 0);

        // Load-use on Rn
        MemRead_EX = 1'b1; Rd_EX = 5'd5; Rn_ID = 5'd5;
        mid();
        chk_ctrl("lu_rn_ctrl", C_LU);
        tick();
        idle_inputs();
        chk("lu_rn_stall_cnt", stall_count, 1);
        // XZR destination never hazards
        MemRead_EX = 1'b1; Rd_EX = 5'd31; Rn_ID = 5'd31; Rm_ID = 5'd31;
        mid();
        chk_ctrl("lu_xzr_ctrl", C_DEF);
        tick();
        chk("lu_xzr_stall_cnt", stall_count, 1);
        // Load-use on Rm, and same regs without MemRead
        idle_inputs();
        MemRead_EX = 1'b1; Rd_EX = 5'd7; Rn_ID = 5'd3; Rm_ID = 5'd7;
        mid();
        chk_ctrl("lu_rm_ctrl", C_LU);
        tick();
        MemRead_EX = 1'b0;
        mid();
        chk_ctrl("no_load_ctrl", C_DEF);
        chk("lu_rm_stall_cnt", stall_count, 2);
        // dmem_req low with ready low is not a stall
        idle_inputs();
        mid();
        chk_ctrl("no_req_ctrl", C_DEF);

        // Branch beats load-use
        do_reset();
        Branch_Taken_Mem = 1'b1; MemRead_EX = 1'b1; Rd_EX = 5'd9; Rn_ID = 5'd9;
        mid();
        chk_ctrl("br_vs_lu_ctrl", C_FLUSH);
        tick();
        idle_inputs();
        chk("br_flush_cnt", flush_count, 1);
        chk("br_stall_cnt", stall_count, 0);
        chk("br_state", state, 2'b00);

        // Three wait cycles then ready
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk_ctrl($sformatf("wait_hold_%0d", i), C_HOLD);
            chk($sformatf("wait_state_%0d", i), state, (i == 0) ? 2'b00 : 2'b01);
            tick();
        end
        dmem_ready = 1'b1;
        mid();
        chk_ctrl("wait_release_ctrl", C_DEF);
        chk("wait_release_state", state, 2'b01);
        tick();
        idle_inputs();
        chk("wait_end_state", state, 2'b00);
        chk("wait_stall_cnt", stall_count, 3);

        // Branch masked during hold, taken on the release cycle; load-use during hold also masked
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0; Branch_Taken_Mem = 1'b1;
        mid();
        chk_ctrl("hm_run_ctrl", C_HOLD);
        tick();
        mid();
        chk_ctrl("hm_wait_ctrl", C_HOLD);
        chk("hm_wait_flush_cnt", flush_count, 0);
        tick();
        dmem_ready = 1'b1;
        mid();
        chk_ctrl("hm_release_ctrl", C_FLUSH);
        tick();
        idle_inputs();
        chk("hm_flush_cnt", flush_count, 1);
        chk("hm_stall_cnt", stall_count, 2);
        chk("hm_state", state, 2'b00);

        // Release with a load-use hazard stalls one cycle on the release cycle
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        dmem_ready = 1'b1; MemRead_EX = 1'b1; Rd_EX = 5'd2; Rm_ID = 5'd2; Rn_ID = 5'd4;
        mid();
        chk_ctrl("rel_lu_ctrl", C_LU);
        tick();
        idle_inputs();
        chk("rel_lu_state", state, 2'b00);

        // Timeout: WAIT lasts MAX_WAIT cycles, then ERR
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        for (int i = 1; i <= MAX_WAIT; i++) begin
            chk($sformatf("to_wait_state_%0d", i), state, 2'b01);
            chk($sformatf("to_wait_flag_%0d", i), mem_timeout, 0);
            tick();
        end
        chk("to_err_state", state, 2'b10);
        chk("to_err_flag", mem_timeout, 1);
        // ERR ignores memory release and branches
        dmem_req = 1'b0; Branch_Taken_Mem = 1'b1;
        mid();
        chk_ctrl("to_err_ctrl", C_HOLD);
        tick();
        chk("to_err_sticky_state", state, 2'b10);
        chk("to_err_sticky_flag", mem_timeout, 1);
        chk("to_stall_sat", stall_count, 3);
        chk("to_flush_cnt", flush_count, 0);
        reset = 1'b1;
        mid();
        chk_ctrl("to_reset_ctrl", C_DEF);
        tick();
        reset = 1'b0;
        idle_inputs();
        chk("to_reset_state", state, 2'b00);
        chk("to_reset_flag", mem_timeout, 0);
        chk("to_reset_stall_cnt", stall_count, 0);

        // Counter saturation at 3 with 2-bit counters
        do_reset();
        MemRead_EX = 1'b1; Rd_EX = 5'd12; Rn_ID = 5'd12;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("sat_stall_%0d", i), stall_count, (i > 3) ? 3 : i);
        end
        idle_inputs();
        Branch_Taken_Mem = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("sat_flush_%0d", i), flush_count, (i > 3) ? 3 : i);
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
